// File: rtl/rv_pkg.sv
// Shared ALU codes, operand-select enums and control-bit struct for the rev02 core.
package rv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_AND  = 5'b00001;
    localparam logic [4:0] ALU_OR   = 5'b00010;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b10111;
    localparam logic [4:0] ALU_SLTU = 5'b11000;
    localparam logic [4:0] ALU_BGEU = 5'b10001;
    localparam logic [4:0] ALU_BLTU = 5'b10010;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2,
        SRC_A_RSVD = 2'd3
    } src_a_e;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } src_b_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } id_ex_ctrl_t;

    // x0 is hard-wired zero, so a producer targeting it never forwards.
    function automatic logic fwd_hit(input logic we, input logic [4:0] prod_rd,
                                     input logic [4:0] rs);
        return we && (prod_rd != 5'd0) && (prod_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding select for rs1/rs2: EX/MEM over MEM/WB over register file.
// Purely combinational, no latency; no flow control.
// Shared by the ALU operand mux and the stall-time operand refresh.
module fwd_unit #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] rs1_dat,
    input  logic [XLEN-1:0] rs2_dat,
    input  logic [4:0]      exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [4:0]      mwb_rd,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] fwd_rs1,
    output logic [XLEN-1:0] fwd_rs2
);
    import rv_pkg::*;

    always_comb begin
        fwd_rs1 = rs1_dat;
        if (fwd_hit(exm_reg_write, exm_rd, rs1)) begin
            fwd_rs1 = exm_result;
        end else if (fwd_hit(mwb_reg_write, mwb_rd, rs1)) begin
            fwd_rs1 = mwb_result;
        end

        fwd_rs2 = rs2_dat;
        if (fwd_hit(exm_reg_write, exm_rd, rs2)) begin
            fwd_rs2 = exm_result;
        end else if (fwd_hit(mwb_reg_write, mwb_rd, rs2)) begin
            fwd_rs2 = mwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, ALU operand select and load-use bubbling.
// Latency: one cycle from ID acceptance to EX outputs.
// Backpressure: holds while ex_ready=0 (operands refreshed), stalls ID on load-use or flush.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_alu_ctrl,
    input  logic [1:0]      id_src_a,
    input  logic            id_src_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic [2:0]      id_funct3,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic [4:0]      exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [4:0]      mwb_rd,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [4:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump
);
    import rv_pkg::*;

    logic            ex_valid_q,  ex_valid_d;
    id_ex_ctrl_t     ctrl_q,      ctrl_d;
    logic [4:0]      rd_q,        rd_d;
    logic [4:0]      rs1_q,       rs1_d;
    logic [4:0]      rs2_q,       rs2_d;
    logic [XLEN-1:0] rs1_dat_q,   rs1_dat_d;
    logic [XLEN-1:0] rs2_dat_q,   rs2_dat_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [4:0]      alu_ctrl_q,  alu_ctrl_d;
    src_a_e          src_a_q,     src_a_d;
    src_b_e          src_b_q,     src_b_d;
    logic [2:0]      funct3_q,    funct3_d;

    logic            adv;
    logic            lu_haz;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    id_ex_ctrl_t     ctrl_out;

    fwd_unit #(.XLEN(XLEN)) u_fwd (
        .rs1           (rs1_q),
        .rs2           (rs2_q),
        .rs1_dat       (rs1_dat_q),
        .rs2_dat       (rs2_dat_q),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .mwb_rd        (mwb_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_result    (mwb_result),
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2)
    );

    always_comb begin
        adv    = ex_ready | ~ex_valid_q;
        lu_haz = ex_valid_q & ctrl_q.mem_read & (rd_q != 5'd0) & id_valid &
                 ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
        id_ready = adv & ~lu_haz & ~flush & ~reset;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ctrl_d     = ctrl_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_dat_d  = rs1_dat_q;
        rs2_dat_d  = rs2_dat_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        alu_ctrl_d = alu_ctrl_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        funct3_d   = funct3_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (adv && lu_haz) begin
            ex_valid_d = 1'b0;
        end else if (adv) begin
            ex_valid_d = id_valid;
            ctrl_d     = '{reg_write: id_reg_write, mem_read: id_mem_read,
                           mem_write: id_mem_write, branch: id_branch, jump: id_jump};
            rd_d       = id_rd;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rs1_dat_d  = id_rs1_data;
            rs2_dat_d  = id_rs2_data;
            pc_d       = id_pc;
            imm_d      = id_imm;
            alu_ctrl_d = id_alu_ctrl;
            src_a_d    = src_a_e'(id_src_a);
            src_b_d    = src_b_e'(id_src_b);
            funct3_d   = id_funct3;
        end else begin
            // Capture producers that retire while stalled so their value outlives the bypass.
            rs1_dat_d = fwd_rs1;
            rs2_dat_d = fwd_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_dat_q  <= '0;
            rs2_dat_q  <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            alu_ctrl_q <= '0;
            src_a_q    <= SRC_A_RS1;
            src_b_q    <= SRC_B_RS2;
            funct3_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_dat_q  <= rs1_dat_d;
            rs2_dat_q  <= rs2_dat_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            alu_ctrl_q <= alu_ctrl_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            funct3_q   <= funct3_d;
        end
    end

    always_comb begin
        case (src_a_q)
            SRC_A_RS1: ex_a = fwd_rs1;
            SRC_A_PC:  ex_a = pc_q;
            default:   ex_a = '0;
        endcase
        ex_b          = (src_b_q == SRC_B_IMM) ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
        ctrl_out      = ex_valid_q ? ctrl_q : '0;
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alu_ctrl  = alu_ctrl_q;
    assign ex_pc        = pc_q;
    assign ex_imm       = imm_q;
    assign ex_rd        = rd_q;
    assign ex_funct3    = funct3_q;
    assign ex_reg_write = ctrl_out.reg_write;
    assign ex_mem_read  = ctrl_out.mem_read;
    assign ex_mem_write = ctrl_out.mem_write;
    assign ex_branch    = ctrl_out.branch;
    assign ex_jump      = ctrl_out.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scenario bench for id_ex_stage: expected EX bundles are queued at drive time and popped after the edge.
module tb_id_ex_stage;
    import rv_pkg::*;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [4:0]  id_alu_ctrl;
    logic [1:0]  id_src_a;
    logic        id_src_b;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
    logic [2:0]  id_funct3;
    logic        flush, ex_ready;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_result;
    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data, ex_pc, ex_imm;
    logic [4:0]  ex_alu_ctrl, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  ctl;
    } obs_t;

    obs_t dut_obs;
    obs_t e;
    obs_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;

    assign dut_obs = {ex_valid, ex_a, ex_b, ex_store_data, ex_pc, ex_imm, ex_alu_ctrl,
                      ex_rd, ex_funct3, ex_reg_write, ex_mem_read, ex_mem_write,
                      ex_branch, ex_jump};

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_alu_ctrl(id_alu_ctrl),
        .id_src_a(id_src_a), .id_src_b(id_src_b), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_jump(id_jump), .id_funct3(id_funct3), .flush(flush), .ex_ready(ex_ready),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(input logic v, input logic [31:0] a, b, sd, pc, imm,
                                input logic [4:0] alu, rd, input logic [2:0] f3,
                                input logic [4:0] ctl);
        return '{v: v, a: a, b: b, sd: sd, pc: pc, imm: imm, alu: alu, rd: rd, f3: f3, ctl: ctl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_pc = 0; id_imm = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_alu_ctrl = 0; id_src_a = 0; id_src_b = 0; id_funct3 = 0;
        {id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump} = 5'b0;
        flush = 0; ex_ready = 1;
        exm_rd = 0; exm_reg_write = 0; exm_result = 0;
        mwb_rd = 0; mwb_reg_write = 0; mwb_result = 0;
    endtask

    // ctl = {reg_write, mem_read, mem_write, branch, jump}
    task automatic set_instr(input logic [31:0] pc, imm, d1, d2,
                             input logic [4:0] rd, r1, r2, alu,
                             input logic u1, u2, input logic [1:0] sa, input logic sb,
                             input logic [4:0] ctl, input logic [2:0] f3);
        id_valid = 1; id_pc = pc; id_imm = imm; id_rs1_data = d1; id_rs2_data = d2;
        id_rd = rd; id_rs1 = r1; id_rs2 = r2; id_alu_ctrl = alu;
        id_use_rs1 = u1; id_use_rs2 = u2; id_src_a = sa; id_src_b = sb; id_funct3 = f3;
        {id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump} = ctl;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        set_instr(32'h10, 32'h20, 32'h30, 32'h40, 5'd3, 5'd1, 5'd2, ALU_SUB, 1, 1, 2'd1, 1'b1, 5'b10000, 3'd1);
        #1;
        vecs++;
        if (id_ready !== 1'b0) begin errs++; $display("FAIL reset_id_ready: got %b expected 0", id_ready); end
        tick(); tick();
        exp_q.push_back('0);
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL reset_outputs: got %h expected %h", dut_obs, e); end
        reset = 0;
        idle();
    endtask

    task automatic test_raw_fwd();
        set_instr(32'h100, 0, 32'd3, 32'd4, 5'd5, 5'd1, 5'd2, ALU_ADD, 1, 1, 2'd0, 1'b0, 5'b10000, 3'd0);
        exp_q.push_back(mk(1, 32'd3, 32'd4, 32'd4, 32'h100, 0, ALU_ADD, 5'd5, 3'd0, 5'b10000));
        tick();
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL raw_first: got %h expected %h", dut_obs, e); end
        set_instr(32'h104, 0, 32'hDEAD, 32'd7, 5'd6, 5'd5, 5'd1, ALU_ADD, 1, 1, 2'd0, 1'b0, 5'b10000, 3'd0);
        exm_rd = 5'd5; exm_reg_write = 1; exm_result = 32'h10;
        #1;
        vecs++;
        if (id_ready !== 1'b1) begin errs++; $display("FAIL raw_no_bubble: got %b expected 1", id_ready); end
        exp_q.push_back(mk(1, 32'h10, 32'd7, 32'd7, 32'h104, 0, ALU_ADD, 5'd6, 3'd0, 5'b10000));
        tick();
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL raw_fwd: got %h expected %h", dut_obs, e); end
        idle();
    endtask

    task automatic test_dual_match();
        set_instr(32'h200, 0, 32'd1, 32'd2, 5'd9, 5'd7, 5'd7, ALU_ADD, 1, 1, 2'd0, 1'b0, 5'b10000, 3'd0);
        exm_rd = 5'd7; exm_reg_write = 1; exm_result = 32'hA;
        mwb_rd = 5'd7; mwb_reg_write = 1; mwb_result = 32'hB;
        exp_q.push_back(mk(1, 32'hA, 32'hA, 32'hA, 32'h200, 0, ALU_ADD, 5'd9, 3'd0, 5'b10000));
        tick();
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL dual_exm_wins: got %h expected %h", dut_obs, e); end
        set_instr(32'h204, 0, 32'd0, 32'h33, 5'd10, 5'd0, 5'd3, ALU_ADD, 1, 1, 2'd0, 1'b0, 5'b10000, 3'd0);
        exm_rd = 5'd0; exm_reg_write = 1; exm_result = 32'h99;
        mwb_rd = 5'd3; mwb_reg_write = 1; mwb_result = 32'hB;
        exp_q.push_back(mk(1, 32'd0, 32'hB, 32'hB, 32'h204, 0, ALU_ADD, 5'd10, 3'd0, 5'b10000));
        tick();
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL x0_not_fwd: got %h expected %h", dut_obs, e); end
        idle();
    endtask

    task automatic test_back_to_back_mux();
        logic [4:0] alus [3];
        logic [31:0] pc, imm, a, b;
        logic [1:0] sa;
        logic sb;
        alus[0] = ALU_SUB; alus[1] = ALU_SLT; alus[2] = ALU_BLTU;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h300 + 32'(4 * i);
            imm = 32'h1000 + 32'(i);
            sa = 2'(i + 1);
            sb = (i != 1);
            a = (sa == 2'd1) ? pc : 32'd0;
            b = sb ? imm : 32'h60;
            set_instr(pc, imm, 32'h50, 32'h60, 5'd11, 5'd1, 5'd2, alus[i], 1, 1, sa, sb, 5'b00010, 3'(i));
            exp_q.push_back(mk(1, a, b, 32'h60, pc, imm, alus[i], 5'd11, 3'(i), 5'b00010));
            tick();
            e = exp_q.pop_front(); vecs++;
            if (dut_obs !== e) begin errs++; $display("FAIL operand_mux[%0d]: got %h expected %h", i, dut_obs, e); end
        end
        idle();
    endtask

    task automatic test_load_use();
        set_instr(32'h400, 32'h100, 32'h1000, 32'd0, 5'd8, 5'd2, 5'd0, ALU_ADD, 1, 0, 2'd0, 1'b1, 5'b11000, 3'd2);
        exp_q.push_back(mk(1, 32'h1000, 32'h100, 32'd0, 32'h400, 32'h100, ALU_ADD, 5'd8, 3'd2, 5'b11000));
        tick();
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL lu_load: got %h expected %h", dut_obs, e); end
        set_instr(32'h404, 32'd0, 32'hBAD, 32'h1000, 5'd9, 5'd8, 5'd2, ALU_ADD, 1, 1, 2'd0, 1'b0, 5'b10000, 3'd0);
        #1;
        vecs++;
        if (id_ready !== 1'b0) begin errs++; $display("FAIL lu_stall_ready: got %b expected 0", id_ready); end
        exp_q.push_back(mk(0, 32'h1000, 32'h100, 32'd0, 32'h400, 32'h100, ALU_ADD, 5'd8, 3'd2, 5'b00000));
        tick();
        exm_rd = 5'd8; exm_reg_write = 1; exm_result = 32'h1100;
        #1;
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL lu_bubble: got %h expected %h", dut_obs, e); end
        vecs++;
        if (id_ready !== 1'b1) begin errs++; $display("FAIL lu_release_ready: got %b expected 1", id_ready); end
        exp_q.push_back(mk(1, 32'h77, 32'h1000, 32'h1000, 32'h404, 32'd0, ALU_ADD, 5'd9, 3'd0, 5'b10000));
        tick();
        id_valid = 0;
        exm_reg_write = 0;
        mwb_rd = 5'd8; mwb_reg_write = 1; mwb_result = 32'h77;
        #1;
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL lu_mwb_fwd: got %h expected %h", dut_obs, e); end
        idle();
    endtask

    task automatic test_stall_refresh();
        set_instr(32'h500, 32'd5, 32'd1, 32'd0, 5'd10, 5'd4, 5'd0, ALU_ADD, 1, 0, 2'd0, 1'b1, 5'b10000, 3'd0);
        exp_q.push_back(mk(1, 32'd1, 32'd5, 32'd0, 32'h500, 32'd5, ALU_ADD, 5'd10, 3'd0, 5'b10000));
        tick();
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL stall_capture: got %h expected %h", dut_obs, e); end
        id_valid = 0; ex_ready = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 1) begin
                mwb_rd = 5'd4; mwb_reg_write = 1; mwb_result = 32'h55;
            end else begin
                mwb_reg_write = 0;
            end
            if (c == 4) ex_ready = 1;
            #1;
            exp_q.push_back(mk(1, 32'h55, 32'd5, 32'd0, 32'h500, 32'd5, ALU_ADD, 5'd10, 3'd0, 5'b10000));
            e = exp_q.pop_front(); vecs++;
            if (dut_obs !== e) begin errs++; $display("FAIL stall_refresh[%0d]: got %h expected %h", c, dut_obs, e); end
            if (c != 4) tick();
        end
        tick();
        vecs++;
        if (ex_valid !== 1'b0) begin errs++; $display("FAIL stall_drain: got %b expected 0", ex_valid); end
        idle();
    endtask

    task automatic test_flush();
        set_instr(32'h600, 32'd4, 32'h2000, 32'd0, 5'd8, 5'd2, 5'd0, ALU_ADD, 1, 0, 2'd0, 1'b1, 5'b11000, 3'd2);
        exp_q.push_back(mk(1, 32'h2000, 32'd4, 32'd0, 32'h600, 32'd4, ALU_ADD, 5'd8, 3'd2, 5'b11000));
        tick();
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL flush_load: got %h expected %h", dut_obs, e); end
        set_instr(32'h604, 32'd0, 32'hBAD, 32'd0, 5'd9, 5'd8, 5'd0, ALU_ADD, 1, 0, 2'd0, 1'b0, 5'b10000, 3'd0);
        ex_ready = 0; flush = 1;
        #1;
        vecs++;
        if (id_ready !== 1'b0) begin errs++; $display("FAIL flush_id_ready: got %b expected 0", id_ready); end
        exp_q.push_back(mk(0, 32'h2000, 32'd4, 32'd0, 32'h600, 32'd4, ALU_ADD, 5'd8, 3'd2, 5'b00000));
        tick();
        flush = 0; id_valid = 0;
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL flush_kill: got %h expected %h", dut_obs, e); end
        idle();
    endtask

    task automatic test_reset_mid_hold();
        set_instr(32'h700, 32'h24, 32'h11, 32'h22, 5'd12, 5'd3, 5'd4, ALU_SUB, 1, 1, 2'd1, 1'b0, 5'b10010, 3'd5);
        exp_q.push_back(mk(1, 32'h700, 32'h22, 32'h22, 32'h700, 32'h24, ALU_SUB, 5'd12, 3'd5, 5'b10010));
        tick();
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL hold_capture: got %h expected %h", dut_obs, e); end
        id_valid = 0; ex_ready = 0;
        tick();
        reset = 1;
        #1;
        vecs++;
        if (id_ready !== 1'b0) begin errs++; $display("FAIL hold_reset_ready: got %b expected 0", id_ready); end
        exp_q.push_back('0);
        tick();
        e = exp_q.pop_front(); vecs++;
        if (dut_obs !== e) begin errs++; $display("FAIL hold_reset_clear: got %h expected %h", dut_obs, e); end
        reset = 0;
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_raw_fwd();
        test_dual_match();
        test_back_to_back_mux();
        test_load_use();
        test_stall_refresh();
        test_flush();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the rev02 RISC-V core, sitting directly upstream of the ALU. It registers decoded instruction fields and register-file operands, and resolves EX/MEM and MEM/WB operand forwarding. It selects the ALU operands and presents `a_in`, `b_in` and `ALUControl`-ready values to the ALU. It also detects load-use hazards, inserts bubbles, and honours downstream back-pressure and branch flushes.

## Interface
- `XLEN`, 32: datapath width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: the ID stage presents an instruction.
- `id_ready` out 1: the stage accepts the ID instruction this cycle.
- `id_pc`, `id_imm`, `id_rs1_data`, `id_rs2_data` in XLEN each: decoded values.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register indices.
- `id_use_rs1`, `id_use_rs2` in 1 each: the instruction reads that source.
- `id_alu_ctrl` in 5: ALU operation code.
- `id_src_a` in 2: operand A select; 0 = rs1, 1 = pc, 2 = zero.
- `id_src_b` in 1: operand B select; 0 = rs2, 1 = imm.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_jump` in 1 each: control bits.
- `id_funct3` in 3: passed through for branch/memory sizing.
- `flush` in 1: branch/jump redirect; kill the ID instruction and the EX content.
- `ex_ready` in 1: the downstream EX/MEM stage accepts the EX content this cycle.
- `exm_rd` in 5, `exm_reg_write` in 1, `exm_result` in XLEN: EX/MEM producer.
- `mwb_rd` in 5, `mwb_reg_write` in 1, `mwb_result` in XLEN: MEM/WB producer.
- `ex_valid` out 1: EX holds a live instruction.
- `ex_a`, `ex_b` out XLEN: ALU operands, with forwarding applied.
- `ex_alu_ctrl` out 5: ALU operation code.
- `ex_store_data` out XLEN: forwarded rs2 value.
- `ex_pc`, `ex_imm` out XLEN each: registered values.
- `ex_rd` out 5, `ex_funct3` out 3: registered fields.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_jump` out 1 each: registered control bits, all forced to 0 when `ex_valid`=0.

## Operation
- **Advance.** The stage advances when `adv = ex_ready | ~ex_valid`.
- **Load-use hazard.** `lu_haz = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.
- **id_ready.** `id_ready = adv & ~lu_haz & ~flush`.
- **Next-state priority**, highest first:
  - `reset`: all registers cleared.
  - `flush`: `ex_valid` ← 0.
  - `adv & lu_haz`: bubble; `ex_valid` ← 0.
  - `adv`: capture the ID fields; `ex_valid` ← `id_valid`.
  - Otherwise (hold): fields are unchanged, except the operand refresh below.
- **Forwarding** (combinational, per source, on the registered rs1/rs2):
  - EX/MEM match: `exm_reg_write & exm_rd!=0 & exm_rd==rsX`, which selects `exm_result`.
  - Else MEM/WB match on the same terms, which selects `mwb_result`.
  - Else the registered register-file data.
  - x0 is never forwarded.
- **Operand refresh.** During hold, the registered rs1/rs2 data is overwritten each cycle with its forwarded value. A producer that retires while EX is stalled is therefore not lost.
- **Operand mux.**
  - `ex_a`: `src_a`=0 gives fwd_rs1, 1 gives pc, 2 gives 0, and 3 is reserved (drives 0).
  - `ex_b`: `src_b`=1 gives imm, otherwise fwd_rs2.
  - `ex_store_data` is always fwd_rs2.
- **Branch compares.** Branches use `ex_b` = fwd_rs2 with ALU codes sub, slt, sltu, bgeu or bltu. The stage does not interpret the code.

## Timing
- **Latency.** One cycle from ID acceptance to EX outputs.
- **Combinational paths.** Forwarding and the operand muxes are combinational from the registered state and the `exm_*`/`mwb_*` inputs in the same cycle.
- **Reset values.** All outputs are 0, including `ex_valid`, `ex_alu_ctrl` (00000) and every control bit. `id_ready` is 0 while `reset`=1.
- **Bubble length.** A load-use bubble lasts exactly one cycle. In the next cycle the load has moved to EX/MEM and forwarding supplies the value at the earliest from MEM/WB, which is correct timing for a 1-cycle load.
- **flush with ex_ready=0.** The flush still clears `ex_valid`. The downstream stage treats the dropped instruction as killed.
- **Simultaneous flush and lu_haz.** flush wins.
- **Reset mid-stall.** Reset clears all state next edge; no pending instruction survives.

## Structure
- Shared package `rv_pkg`:
  - ALU codes: ADD 00000, SUB 10000, AND 00001, OR 00010, XOR 00011, SLL 00100, SRL 00101, SRA 00110, SLT 10111, SLTU 11000, BGEU 10001, BLTU 10010.
  - The `src_a`/`src_b` enums.
  - A packed `id_ex_ctrl_t` struct for the control bits.
- Sub-module `fwd_unit`: purely combinational rs1/rs2 forward selection. It is instantiated once and shared by the operand mux and the refresh logic.

## Test plan
- **Back-to-back add→add RAW.** `add x5` followed by `add x6,x5,x1`, with `exm_rd=5`, `exm_result=0x10` → `ex_a=0x10`, no bubble.
- **Dual-match priority.** `exm_rd=mwb_rd=7`, `exm_result=0xA`, `mwb_result=0xB` → EX/MEM wins; `exm_rd=0` with `exm_reg_write=1` → never forwarded, register-file value used.
- **Load-use.** `lw x8` followed by `add x9,x8,x2` → `id_ready`=0 for 1 cycle, `ex_valid`=0 for 1 cycle, then `ex_a=mwb_result`.
- **Stall refresh.** `ex_ready=0` for 3 cycles while the MEM/WB producer `0x55` for rs1 is present only in cycle 1 → `ex_a=0x55` in cycles 2–3 and at release.
- **Flush priority.** `flush` together with `lu_haz` and `ex_ready=0` → next `ex_valid=0` and all control bits 0; `id_ready`=0 during flush.
- **Reset mid-hold.** `reset` asserted during hold → next cycle all outputs 0, `ex_alu_ctrl`=00000.
